// File: rtl/seq_pkg.sv
// Shared opcodes, field positions and FSM state type for the instruction sequencer.
// Field positions assume the default 32-bit instruction word.
package seq_pkg;

   localparam logic [7:0] OP_HALT = 8'h00;
   localparam logic [7:0] OP_JMP  = 8'h01;
   localparam logic [7:0] OP_LOOP = 8'h02;

   localparam int unsigned OPC_MSB      = 31;
   localparam int unsigned OPC_LSB      = 24;
   localparam int unsigned OPC_W        = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned LOOP_CNT_MSB = 23;
   localparam int unsigned LOOP_CNT_LSB = 16;
   localparam int unsigned LOOP_CNT_W   = LOOP_CNT_MSB - LOOP_CNT_LSB + 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      ISSUE,
      DONE
   } seq_state_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classification for the sequencer (HALT/JMP, plus LOOP
// when SEQ_LOOP_EN is defined).
module seq_decode
   import seq_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned AW          = 8
) (
   input  logic [INSTR_WIDTH-1:0] i_instr,
   output logic                   o_is_halt,
   output logic                   o_is_jmp,
`ifdef SEQ_LOOP_EN
   output logic                   o_is_loop,
   output logic [LOOP_CNT_W-1:0]  o_count,
`endif
   output logic [AW-1:0]          o_target
);

   logic [OPC_W-1:0] w_opcode;
   logic             w_unused;

   // Opcode always sits in the top byte, whatever the instruction width.
   assign w_opcode  = i_instr[INSTR_WIDTH-1 -: OPC_W];
   assign o_is_halt = (w_opcode == OP_HALT);
   assign o_is_jmp  = (w_opcode == OP_JMP);
   assign o_target  = i_instr[AW-1:0];
   assign w_unused  = ^i_instr;

`ifdef SEQ_LOOP_EN
   assign o_is_loop = (w_opcode == OP_LOOP);
   assign o_count   = i_instr[LOOP_CNT_MSB:LOOP_CNT_LSB];
`endif

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch/sequencer: walks program memory, executes HALT/JMP locally and
// issues all other words over valid/ready. Define SEQ_LOOP_EN to execute LOOP locally.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned DEPTH       = 256,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [AW-1:0]          rd_addr,
   input  logic [INSTR_WIDTH-1:0] rd_data,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [AW-1:0]          pc,
   output logic                   busy,
   output logic                   halted
);

   seq_state_t             r_state;
   seq_state_t             w_next_state;
   logic [AW-1:0]          r_pc;
   logic [AW-1:0]          w_pc_next;
   logic [AW-1:0]          w_pc_inc;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [INSTR_WIDTH-1:0] w_instr_next;
   logic                   w_is_halt;
   logic                   w_is_jmp;
   logic [AW-1:0]          w_target;

`ifdef SEQ_LOOP_EN
   logic                   w_is_loop;
   logic [LOOP_CNT_W-1:0]  w_count;
   logic [LOOP_CNT_W-1:0]  r_loop_cnt;
   logic [LOOP_CNT_W-1:0]  w_loop_cnt_next;
   logic [LOOP_CNT_W-1:0]  w_loop_eff;
   logic                   r_loop_armed;
   logic                   w_loop_armed_next;
`endif

   seq_decode #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .AW          (AW)
   ) u_decode (
      .i_instr   (rd_data),
      .o_is_halt (w_is_halt),
      .o_is_jmp  (w_is_jmp),
`ifdef SEQ_LOOP_EN
      .o_is_loop (w_is_loop),
      .o_count   (w_count),
`endif
      .o_target  (w_target)
   );

   // Explicit wrap keeps the modulo correct for non-power-of-two depths.
   assign w_pc_inc = (r_pc == AW'(DEPTH - 1)) ? '0 : r_pc + AW'(1);

   always_comb begin
      w_next_state = r_state;
      w_pc_next    = r_pc;
      w_instr_next = r_instr;
`ifdef SEQ_LOOP_EN
      w_loop_cnt_next   = r_loop_cnt;
      w_loop_armed_next = r_loop_armed;
      w_loop_eff        = r_loop_armed ? r_loop_cnt : w_count;
`endif
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_pc_next    = '0;
               w_next_state = FETCH;
            end
         end
         FETCH: w_next_state = DECODE;
         DECODE: begin
            w_instr_next = rd_data;
            if (w_is_halt) begin
               w_next_state = DONE;
            end else if (w_is_jmp) begin
               w_pc_next    = w_target;
               w_next_state = FETCH;
`ifdef SEQ_LOOP_EN
            end else if (w_is_loop) begin
               // Arming and the first decrement collapse into one step, so N gives N+1 passes.
               if (w_loop_eff != '0) begin
                  w_loop_cnt_next   = w_loop_eff - LOOP_CNT_W'(1);
                  w_loop_armed_next = 1'b1;
                  w_pc_next         = w_target;
               end else begin
                  w_loop_cnt_next   = '0;
                  w_loop_armed_next = 1'b0;
                  w_pc_next         = w_pc_inc;
               end
               w_next_state = FETCH;
`endif
            end else begin
               w_next_state = ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               w_pc_next    = w_pc_inc;
               w_next_state = FETCH;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_instr <= '0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_pc_next;
         r_instr <= w_instr_next;
      end
   end

`ifdef SEQ_LOOP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_loop_cnt   <= '0;
         r_loop_armed <= 1'b0;
      end else begin
         r_loop_cnt   <= w_loop_cnt_next;
         r_loop_armed <= w_loop_armed_next;
      end
   end
`endif

   assign rd_addr     = r_pc;
   assign pc          = r_pc;
   assign instr_out   = r_instr;
   assign instr_valid = (r_state == ISSUE);
   assign busy        = (r_state == FETCH) || (r_state == DECODE) || (r_state == ISSUE);
   assign halted      = (r_state == DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (default DEPTH plus a DEPTH=4 wrap instance).
// Loop expectations follow SEQ_LOOP_EN.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        instr_ready;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [7:0]  pc;
   logic        busy;
   logic        halted;

   logic        start4;
   logic        ready4;
   logic [1:0]  rd_addr4;
   logic [31:0] rd_data4;
   logic [31:0] instr_out4;
   logic        valid4;
   logic [1:0]  pc4;
   logic        busy4;
   logic        halted4;

   logic [31:0] mem  [256];
   logic [31:0] mem4 [4];

   int          checks = 0;
   int          errors = 0;

   logic [31:0] iss_val [16];
   logic [7:0]  iss_pc  [16];
   int          iss_n   [16];
   int          n_iss;
   int          n_halt;

   always #5 clk = ~clk;

   always @(posedge clk) rd_data  <= mem[rd_addr];
   always @(posedge clk) rd_data4 <= mem4[rd_addr4];

   instr_sequencer #(
      .INSTR_WIDTH (32),
      .DEPTH       (256)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted)
   );

   instr_sequencer #(
      .INSTR_WIDTH (32),
      .DEPTH       (4)
   ) u_dut4 (
      .clk         (clk),
      .rst         (rst),
      .start       (start4),
      .rd_addr     (rd_addr4),
      .rd_data     (rd_data4),
      .instr_out   (instr_out4),
      .instr_valid (valid4),
      .instr_ready (ready4),
      .pc          (pc4),
      .busy        (busy4),
      .halted      (halted4)
   );

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   // Pulses start for one edge, then records every handshake; n counts negedges after the start edge.
   task automatic run_until_halt(input int budget);
      n_iss  = 0;
      n_halt = -1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 1; n <= budget; n++) begin
         if (n > 1) @(negedge clk);
         if (instr_valid && instr_ready && n_iss < 16) begin
            iss_val[n_iss] = instr_out;
            iss_pc[n_iss]  = pc;
            iss_n[n_iss]   = n;
            n_iss++;
         end
         if (halted) begin
            n_halt = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
      checks++; if (rd_addr !== 8'd0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 00", rd_addr); end
      checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h expected 00000000", instr_out); end
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_start: busy got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      clear_mem();
      mem[0] = 32'h10000001;
      mem[1] = 32'h10000002;
      instr_ready = 1'b1;
      run_until_halt(40);
      checks++; if (n_iss !== 2) begin errors++; $display("FAIL basic_count: got %0d expected 2", n_iss); end
      checks++; if (iss_val[0] !== 32'h10000001) begin errors++; $display("FAIL basic_first: got %h expected 10000001", iss_val[0]); end
      checks++; if (iss_n[0] !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", iss_n[0]); end
      checks++; if (iss_val[1] !== 32'h10000002) begin errors++; $display("FAIL basic_second: got %h expected 10000002", iss_val[1]); end
      checks++; if (iss_n[1] !== 6) begin errors++; $display("FAIL basic_spacing: got %0d expected 6", iss_n[1]); end
      checks++; if (n_halt !== 9) begin errors++; $display("FAIL basic_halt_cycle: got %0d expected 9", n_halt); end
      checks++; if (pc !== 8'd2) begin errors++; $display("FAIL basic_halt_pc: got %h expected 02", pc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
   endtask

   // Stall in first ISSUE; start is also raised mid-stall and must be ignored.
   task automatic test_stall();
      instr_ready = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (n > 1) @(negedge clk);
         if (n >= 3 && n <= 7) begin
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", n, instr_valid); end
            checks++; if (instr_out !== 32'h10000001) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected 10000001", n, instr_out); end
            checks++; if (pc !== 8'd0) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 00", n, pc); end
         end
         if (n == 4) start = 1'b1;
         if (n == 7) begin
            start = 1'b0;
            instr_ready = 1'b1;
         end
         if (n == 8) begin
            checks++; if (pc !== 8'd1) begin errors++; $display("FAIL stall_pc_after: got %h expected 01", pc); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_after: got %b expected 0", instr_valid); end
         end
      end
      for (int n = 0; n < 20 && !halted; n++) @(negedge clk);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_halted: got %b expected 1", halted); end
   endtask

   task automatic test_jmp();
      clear_mem();
      mem[0] = 32'h01000003;
      mem[1] = 32'h000000AA;
      mem[2] = 32'h000000BB;
      mem[3] = 32'h20000000;
      instr_ready = 1'b1;
      run_until_halt(40);
      checks++; if (n_iss !== 1) begin errors++; $display("FAIL jmp_count: got %0d expected 1", n_iss); end
      checks++; if (iss_val[0] !== 32'h20000000) begin errors++; $display("FAIL jmp_instr: got %h expected 20000000", iss_val[0]); end
      checks++; if (iss_n[0] !== 5) begin errors++; $display("FAIL jmp_latency: got %0d expected 5", iss_n[0]); end
      checks++; if (iss_pc[0] !== 8'd3) begin errors++; $display("FAIL jmp_pc: got %h expected 03", iss_pc[0]); end
      checks++; if (n_halt !== 8) begin errors++; $display("FAIL jmp_halt_cycle: got %0d expected 8", n_halt); end
   endtask

   task automatic test_loop();
      clear_mem();
      mem[0] = 32'h30000000;
      mem[1] = 32'h02030000;
      instr_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         run_until_halt(80);
`ifdef SEQ_LOOP_EN
         checks++; if (n_iss !== 4) begin errors++; $display("FAIL loop_count[%0d]: got %0d expected 4", r, n_iss); end
         for (int k = 0; k < 4; k++) begin
            checks++; if (iss_val[k] !== 32'h30000000) begin errors++; $display("FAIL loop_instr[%0d]: got %h expected 30000000", k, iss_val[k]); end
         end
         checks++; if (iss_n[3] !== 18) begin errors++; $display("FAIL loop_last_cycle: got %0d expected 18", iss_n[3]); end
         checks++; if (n_halt !== 23) begin errors++; $display("FAIL loop_halt_cycle: got %0d expected 23", n_halt); end
`else
         checks++; if (n_iss !== 2) begin errors++; $display("FAIL loop_count[%0d]: got %0d expected 2", r, n_iss); end
         checks++; if (iss_val[0] !== 32'h30000000) begin errors++; $display("FAIL loop_instr0: got %h expected 30000000", iss_val[0]); end
         checks++; if (iss_val[1] !== 32'h02030000) begin errors++; $display("FAIL loop_instr1: got %h expected 02030000", iss_val[1]); end
         checks++; if (n_halt !== 9) begin errors++; $display("FAIL loop_halt_cycle: got %0d expected 9", n_halt); end
`endif
      end
   endtask

   task automatic test_wrap();
      logic [1:0]  exp_pc [6];
      logic [1:0]  got_pc [6];
      logic [31:0] got_v  [6];
      int          cnt;
      exp_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      mem4[0] = 32'h40000000;
      mem4[1] = 32'h40000001;
      mem4[2] = 32'h40000002;
      mem4[3] = 32'h40000003;
      ready4 = 1'b1;
      cnt = 0;
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      for (int n = 1; n <= 40 && cnt < 6; n++) begin
         if (n > 1) @(negedge clk);
         if (valid4 && ready4) begin
            got_pc[cnt] = pc4;
            got_v[cnt]  = instr_out4;
            cnt++;
         end
      end
      checks++; if (cnt !== 6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", cnt); end
      for (int k = 0; k < 6; k++) begin
         if (k < cnt) begin
            checks++; if (got_pc[k] !== exp_pc[k]) begin errors++; $display("FAIL wrap_pc[%0d]: got %0d expected %0d", k, got_pc[k], exp_pc[k]); end
            checks++; if (got_v[k] !== mem4[exp_pc[k]]) begin errors++; $display("FAIL wrap_instr[%0d]: got %h expected %h", k, got_v[k], mem4[exp_pc[k]]); end
         end
      end
   endtask

   task automatic test_reset_mid_issue();
      clear_mem();
      mem[0] = 32'h10000001;
      mem[1] = 32'h10000002;
      instr_ready = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", instr_valid); end
      rst = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", instr_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
      checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL rst_async_instr: got %h expected 00000000", instr_out); end
      checks++; if (pc !== 8'd0) begin errors++; $display("FAIL rst_async_pc: got %h expected 00", pc); end
      checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL rst_async_valid4: got %b expected 0", valid4); end
      @(negedge clk) rst = 1'b1;
      instr_ready = 1'b1;
      run_until_halt(40);
      checks++; if (n_iss !== 2) begin errors++; $display("FAIL rst_restart_count: got %0d expected 2", n_iss); end
      checks++; if (iss_pc[0] !== 8'd0) begin errors++; $display("FAIL rst_restart_pc: got %h expected 00", iss_pc[0]); end
      checks++; if (iss_val[0] !== 32'h10000001) begin errors++; $display("FAIL rst_restart_instr: got %h expected 10000001", iss_val[0]); end
   endtask

   initial begin
      start       = 1'b0;
      start4      = 1'b0;
      instr_ready = 1'b1;
      ready4      = 1'b1;
      clear_mem();
      for (int i = 0; i < 4; i++) mem4[i] = 32'h0;
      test_reset();
      test_basic();
      test_stall();
      test_jmp();
      test_loop();
      test_wrap();
      test_reset_mid_issue();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
